// File: rtl/counter_pkg.sv
// Shared types for the up/down counter: default width, count type and direction encoding.
package counter_pkg;

  localparam int COUNT_W = 8;

  typedef logic [COUNT_W-1:0] count_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage : counter_pkg

// File: rtl/counter_8bit.sv
// Free-running up/down counter with a registered wrap pulse and a combinational zero flag.
// Note: rst_n is active-HIGH despite its name.
module counter_8bit
  import counter_pkg::*;
#(
  parameter int               WIDTH       = COUNT_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  // Returns {wrap, next_count}; the wrap bit flags a roll-over in the chosen direction.
  function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] cur, input dir_e dir);
    logic [WIDTH:0] res;
    if (dir == DIR_DOWN) res = {cur == '0, cur - ONE};
    else                 res = {cur == MAX_VAL, cur + ONE};
    return res;
  endfunction

  dir_e dir;
  assign dir = dir_e'(down);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count <= RESET_VALUE;
      wrap  <= 1'b0;
    end else begin
      {wrap, count} <= step(count, dir);
    end
  end

  assign zero = (count == '0);

endmodule : counter_8bit

// File: tb/tb_counter_8bit.sv
// Self-checking bench for counter_8bit: directed scenarios plus random direction and reset activity.
module tb_counter_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       down;
  logic [7:0] count;
  logic       wrap;
  logic       zero;

  int passed = 0;
  int total  = 0;

  // Reference model state: plain integer arithmetic on the count value.
  int  m_count = 0;
  bit  m_wrap  = 1'b0;

  counter_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .down  (down),
    .count (count),
    .wrap  (wrap),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, {24'b0, count}, m_count);
    check({tag, ".wrap"},  {31'b0, wrap},  {31'b0, m_wrap});
    check({tag, ".zero"},  {31'b0, zero},  (m_count == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic model_step(input bit dn);
    int nxt;
    nxt     = m_count + (dn ? -1 : 1);
    m_wrap  = (nxt < 0) || (nxt > 255);
    m_count = (nxt + 256) % 256;
  endtask

  // One clock edge: model advances with the direction present at the edge.
  task automatic tick(input string tag, input bit chk);
    @(posedge clk);
    model_step(down);
    #1;
    if (chk) check_all(tag);
  endtask

  task automatic assert_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    m_count = 0;
    m_wrap  = 1'b0;
    #1;
    check_all(tag);
  endtask

  // Deassert 1 ns before the next rising edge.
  task automatic release_reset(input bit dn);
    @(posedge clk);
    #9;
    down  = dn;
    rst_n = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    down  = 1'b0;
    #1;
    check_all("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_all("reset_hold");

    // Up count from reset, released just before an edge.
    release_reset(1'b0);
    for (int i = 0; i < 5; i++) tick("up", 1'b1);
    repeat (2) tick("up7", 1'b1);
    check("pre_mid_reset", {24'b0, count}, 32'd7);
    #3;
    rst_n = 1'b1;
    m_count = 0;
    m_wrap  = 1'b0;
    #1;
    check_all("mid_reset");

    // Underflow from reset.
    release_reset(1'b1);
    tick("underflow", 1'b1);
    tick("after_underflow", 1'b1);

    // Overflow after counting up to 254.
    assert_reset("reset2");
    release_reset(1'b0);
    for (int i = 0; i < 254; i++) tick("climb", 1'b0);
    check("at254", {24'b0, count}, 32'd254);
    for (int i = 0; i < 3; i++) tick("overflow", 1'b1);

    // Direction switch around zero without crossing it.
    assert_reset("reset3");
    release_reset(1'b0);
    for (int i = 0; i < 3; i++) tick("sw_up", 1'b1);
    @(negedge clk) down = 1'b1;
    for (int i = 0; i < 3; i++) tick("sw_down", 1'b1);
    @(negedge clk) down = 1'b0;
    for (int i = 0; i < 2; i++) tick("sw_up2", 1'b1);

    // Random direction with occasional mid-cycle reset pulses.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      down = 1'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b1;
        m_count = 0;
        m_wrap  = 1'b0;
        #1;
        check_all("rand_reset");
        release_reset(1'($urandom));
      end
      tick("rand", 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_counter_8bit
